// File: rtl/sram_cascade_pkg.sv
// Shared types and default geometry for the cascaded SRAM block.
package sram_cascade_pkg;

  typedef enum logic {
    INIT,
    IDLE
  } cascadeStateT;

  localparam int unsigned DEF_LANE_W = 4;
  localparam int unsigned DEF_LANES  = 2;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_BANK_W = 1;

endpackage

// File: rtl/sram_lane.sv
// One lane of one bank: synchronous-write array with a registered read port.
module sram_lane #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEn,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Storage write; contents are cleared by the controller's init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (writeEn) mem[addr] <= wdata;
  end

  // Registered read; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset)       rdata <= '0;
    else if (readEn) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_cascade.sv
// Horizontally (lanes) and vertically (banks) cascaded SRAM with an init clear sweep.
// Optional per-lane even parity: define SRAM_CASCADE_PARITY_EN.
module sram_cascade
  import sram_cascade_pkg::*;
#(
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BANK_W = DEF_BANK_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipSelect,
  input  logic                      writeEnable,
  input  logic [LANES-1:0]          laneEnable,
  input  logic [BANK_W+ADDR_W-1:0]  address,
  input  logic [LANE_W*LANES-1:0]   dataIn,
  output logic [LANE_W*LANES-1:0]   dataOut,
  output logic                      ready,
  output logic                      dataValid
`ifdef SRAM_CASCADE_PARITY_EN
  ,
  output logic [LANES-1:0]          parityErr
`endif
);

  localparam int unsigned BANKS = 2**BANK_W;
  localparam int unsigned TOTAL = 2**(BANK_W+ADDR_W);
  localparam int unsigned CNT_W = BANK_W+ADDR_W+1;
`ifdef SRAM_CASCADE_PARITY_EN
  localparam int unsigned PW = LANE_W+1;
`else
  localparam int unsigned PW = LANE_W;
`endif

  cascadeStateT      state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic              initWr;
  logic              accept;
  logic              acceptRd;
  logic [BANK_W-1:0] reqBank;
  logic [BANK_W-1:0] initBank;
  logic [BANK_W-1:0] rdBank;
  logic [ADDR_W-1:0] memAddr;

  logic [LANES-1:0]  bankWe [BANKS];
  logic              bankRe [BANKS];
  logic [PW-1:0]     laneWdata [LANES];
  logic [PW-1:0]     rdWord [BANKS][LANES];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= nextState;
  end

  // Next state and control; the counter runs one past the last location so
  // IDLE is entered the cycle after the final clear.
  always_comb begin
    nextState = state;
    ready     = 1'b0;
    initWr    = 1'b0;
    case (state)
      INIT: begin
        if (cnt == CNT_W'(TOTAL)) nextState = IDLE;
        else                      initWr    = !reset;
      end
      IDLE: ready = 1'b1;
      default: nextState = INIT;
    endcase
  end

  // Init sweep counter.
  always_ff @(posedge clk) begin
    if (reset)                                   cnt <= '0;
    else if (state == INIT && cnt != CNT_W'(TOTAL)) cnt <= cnt + 1'b1;
  end

  assign accept   = chipSelect && ready && !reset;
  assign acceptRd = accept && !writeEnable;
  assign reqBank  = address[ADDR_W +: BANK_W];
  assign initBank = cnt[ADDR_W +: BANK_W];
  assign memAddr  = initWr ? cnt[ADDR_W-1:0] : address[ADDR_W-1:0];

  // Per-lane write data and per-bank/lane strobes.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      laneWdata[k] = '0;
`ifdef SRAM_CASCADE_PARITY_EN
      if (!initWr) laneWdata[k] = {^dataIn[k*LANE_W +: LANE_W], dataIn[k*LANE_W +: LANE_W]};
`else
      if (!initWr) laneWdata[k] = dataIn[k*LANE_W +: LANE_W];
`endif
    end
    for (int unsigned b = 0; b < BANKS; b++) begin
      bankRe[b] = acceptRd && (reqBank == BANK_W'(b));
      for (int unsigned k = 0; k < LANES; k++) begin
        bankWe[b][k] = (initWr && (initBank == BANK_W'(b))) ||
                       (accept && writeEnable && laneEnable[k] && (reqBank == BANK_W'(b)));
      end
    end
  end

  // Read-completion strobe and the bank that supplies dataOut.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataValid <= 1'b0;
      rdBank    <= '0;
    end else begin
      dataValid <= acceptRd;
      if (acceptRd) rdBank <= reqBank;
    end
  end

  for (genvar b = 0; b < int'(BANKS); b++) begin : gBank
    for (genvar k = 0; k < int'(LANES); k++) begin : gLane
      sram_lane #(.WIDTH(PW), .ADDR_W(ADDR_W)) uLane (
        .clk    (clk),
        .reset  (reset),
        .writeEn(bankWe[b][k]),
        .readEn (bankRe[b]),
        .addr   (memAddr),
        .wdata  (laneWdata[k]),
        .rdata  (rdWord[b][k])
      );
    end
  end

  // Output select from the registered lane words; holds because lane registers
  // and rdBank only change on a read.
  always_comb begin
    dataOut = '0;
`ifdef SRAM_CASCADE_PARITY_EN
    parityErr = '0;
`endif
    for (int unsigned k = 0; k < LANES; k++) begin
      dataOut[k*LANE_W +: LANE_W] = rdWord[rdBank][k][LANE_W-1:0];
`ifdef SRAM_CASCADE_PARITY_EN
      parityErr[k] = dataValid && (^rdWord[rdBank][k]);
`endif
    end
  end

endmodule

// File: tb/tb_sram_cascade.sv
// Directed self-checking bench for sram_cascade at default parameters.
module tb_sram_cascade;

  logic       clk = 1'b0;
  logic       reset;
  logic       chipSelect;
  logic       writeEnable;
  logic [1:0] laneEnable;
  logic [3:0] address;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       ready;
  logic       dataValid;
`ifdef SRAM_CASCADE_PARITY_EN
  logic [1:0] parityErr;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sram_cascade #(.LANE_W(4), .LANES(2), .ADDR_W(3), .BANK_W(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipSelect (chipSelect),
    .writeEnable(writeEnable),
    .laneEnable (laneEnable),
    .address    (address),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .ready      (ready),
    .dataValid  (dataValid)
`ifdef SRAM_CASCADE_PARITY_EN
    ,
    .parityErr  (parityErr)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from reset release until ready; bounded.
  task automatic waitReady(input string tag, input logic holdCs);
    int unsigned n = 0;
    logic sawValid = 1'b0;
    chipSelect  = holdCs;
    writeEnable = 1'b1;
    laneEnable  = 2'b11;
    dataIn      = 8'hEE;
    address     = 4'h3;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (dataValid) sawValid = 1'b1;
      if (n == 9 && holdCs) writeEnable = 1'b0;
      if (n == 10 && holdCs) writeEnable = 1'b1;
    end
    chipSelect = 1'b0;
    checkVal({tag, "_cycles"}, n, 17);
    checkVal({tag, "_noValid"}, {31'd0, sawValid}, 0);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [7:0] d, input logic [1:0] le);
    chipSelect  = 1'b1;
    writeEnable = 1'b1;
    address     = a;
    dataIn      = d;
    laneEnable  = le;
    tick();
    chipSelect  = 1'b0;
  endtask

  task automatic readWord(input string tag, input logic [3:0] a, input logic [7:0] exp,
                          input logic [1:0] expPar);
    chipSelect  = 1'b1;
    writeEnable = 1'b0;
    laneEnable  = 2'b00;
    address     = a;
    tick();
    chipSelect  = 1'b0;
    checkVal({tag, "_valid"}, {31'd0, dataValid}, 1);
    checkVal({tag, "_data"}, {24'd0, dataOut}, {24'd0, exp});
`ifdef SRAM_CASCADE_PARITY_EN
    checkVal({tag, "_par"}, {30'd0, parityErr}, {30'd0, expPar});
`else
    if (expPar != 2'b00) checkVal({tag, "_parUnexpected"}, {30'd0, expPar}, 0);
`endif
    tick();
    checkVal({tag, "_validDrop"}, {31'd0, dataValid}, 0);
    checkVal({tag, "_hold"}, {24'd0, dataOut}, {24'd0, exp});
  endtask

  initial begin
    reset = 1'b1; chipSelect = 1'b0; writeEnable = 1'b0;
    laneEnable = 2'b00; address = '0; dataIn = '0;
    repeat (3) tick();
    checkVal("rst_dataOut", {24'd0, dataOut}, 0);
    checkVal("rst_valid", {31'd0, dataValid}, 0);
    checkVal("rst_ready", {31'd0, ready}, 0);
`ifdef SRAM_CASCADE_PARITY_EN
    checkVal("rst_par", {30'd0, parityErr}, 0);
`endif
    reset = 1'b0;
    waitReady("init", 1'b0);

    for (int a = 0; a < 16; a++) readWord("clear", 4'(a), 8'h00, 2'b00);

    writeWord(4'h3, 8'hA5, 2'b11);
    readWord("wrA5", 4'h3, 8'hA5, 2'b00);
    writeWord(4'h3, 8'hFF, 2'b10);
    readWord("laneHi", 4'h3, 8'hF5, 2'b00);
    writeWord(4'h3, 8'h0C, 2'b01);
    readWord("laneLo", 4'h3, 8'hFC, 2'b00);

    writeWord(4'h2, 8'h11, 2'b11);
    writeWord(4'hA, 8'h22, 2'b11);
    readWord("bank0", 4'h2, 8'h11, 2'b00);
    readWord("bank1", 4'hA, 8'h22, 2'b00);
    readWord("alias3", 4'hB, 8'h00, 2'b00);
    readWord("keep3", 4'h3, 8'hFC, 2'b00);
    writeWord(4'h2, 8'h77, 2'b00);
    readWord("noLane", 4'h2, 8'h11, 2'b00);

    // Reset coinciding with a read request suppresses dataValid.
    chipSelect = 1'b1; writeEnable = 1'b0; address = 4'hA; reset = 1'b1;
    tick();
    checkVal("rstRead_valid", {31'd0, dataValid}, 0);
    checkVal("rstRead_data", {24'd0, dataOut}, 0);
    chipSelect = 1'b0;
    reset = 1'b0;

    // Requests during INIT, then reset mid-INIT: sweep restarts from 0.
    chipSelect = 1'b1; writeEnable = 1'b1; laneEnable = 2'b11; dataIn = 8'hEE; address = 4'h3;
    repeat (6) begin
      tick();
      checkVal("initBusy", {31'd0, ready}, 0);
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    waitReady("reinit", 1'b1);
    for (int a = 0; a < 16; a++) readWord("reclear", 4'(a), 8'h00, 2'b00);

`ifdef SRAM_CASCADE_PARITY_EN
    writeWord(4'h4, 8'h5A, 2'b11);
    readWord("parOk", 4'h4, 8'h5A, 2'b00);
    dut.gBank[0].gLane[1].uLane.mem[4][0] = ~dut.gBank[0].gLane[1].uLane.mem[4][0];
    readWord("parFlip", 4'h4, 8'h4A, 2'b10);
    checkVal("parIdle", {30'd0, parityErr}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
